pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_ret_stack.sv | 76 +++++++
 rtl/pc_unit.sv | 130 +++++++++++++
 tb/tb_pc_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared pc_ctrl width and operation encodings for the program
//               counter unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam int PC_CTRL_W = 3;

    localparam logic [PC_CTRL_W-1:0] PC_HOLD   = 3'b000;
    localparam logic [PC_CTRL_W-1:0] PC_INC    = 3'b001;
    localparam logic [PC_CTRL_W-1:0] PC_JUMP   = 3'b010;
    localparam logic [PC_CTRL_W-1:0] PC_BRANCH = 3'b011;
    localparam logic [PC_CTRL_W-1:0] PC_CALL   = 3'b100;
    localparam logic [PC_CTRL_W-1:0] PC_RET    = 3'b101;

endpackage : pc_pkg

`default_nettype wire

// File: rtl/pc_ret_stack.sv
// ============================================================================
// Module      : pc_ret_stack
// Description : LIFO return-address stack with registered full/empty flags.
//               Push wins over pop; overflowing pushes and underflowing pops
//               are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ret_stack #(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              full,
    output logic              empty
);

    localparam int             PTR_W       = $clog2(STACK_DEPTH);
    localparam logic [PTR_W:0] c_DEPTH_MAX = (PTR_W + 1)'(STACK_DEPTH);

    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
    logic [PTR_W:0]    r_depth;
    logic [PTR_W:0]    w_depth_nxt;
    logic              r_full;
    logic              r_empty;
    logic              w_do_push;
    logic              w_do_pop;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [PTR_W-1:0]  w_rd_idx;

    assign w_do_push = push & ~r_full;
    assign w_do_pop  = pop & ~r_empty & ~push;
    assign w_wr_idx  = r_depth[PTR_W-1:0];
    assign w_rd_idx  = w_wr_idx - PTR_W'(1);

    always_comb begin
        w_depth_nxt = r_depth;
        if (w_do_push) begin
            w_depth_nxt = r_depth + (PTR_W + 1)'(1);
        end else if (w_do_pop) begin
            w_depth_nxt = r_depth - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_depth <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_depth <= w_depth_nxt;
            r_full  <= (w_depth_nxt == c_DEPTH_MAX);
            r_empty <= (w_depth_nxt == '0);
        end
    end

    // Entry storage is deliberately left unreset; slots above depth are never read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    assign top_data = r_mem[w_rd_idx];
    assign full     = r_full;
    assign empty    = r_empty;

endmodule : pc_ret_stack

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module      : pc_unit
// Description : Program counter with inc/jump/branch and optional return
//               stack. Define PC_UNIT_STACK_EN to enable CALL/RET stacking;
//               otherwise CALL acts as JUMP and RET as HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int OFFS_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_in,
    input  logic [PC_CTRL_W-1:0] pc_ctrl,
    input  logic [OFFS_W-1:0]    offset_addr,
    output logic [ADDR_W-1:0]    pc_out,
    output logic                 stk_full,
    output logic                 stk_empty,
    output logic                 stk_err
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_zext;
    logic [ADDR_W-1:0] w_sext;

    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_zext   = ADDR_W'(offset_addr);
    assign w_sext   = ADDR_W'($signed(offset_addr));

`ifdef PC_UNIT_STACK_EN
    logic              w_push;
    logic              w_pop;
    logic              w_err_nxt;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_top;
    logic              r_err;
`endif

    always_comb begin
        w_pc_nxt = r_pc;
`ifdef PC_UNIT_STACK_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_nxt = 1'b0;
`endif
        if (en_in) begin
            case (pc_ctrl)
                PC_INC:    w_pc_nxt = w_pc_inc;
                PC_JUMP:   w_pc_nxt = w_zext;
                PC_BRANCH: w_pc_nxt = r_pc + w_sext;
`ifdef PC_UNIT_STACK_EN
                PC_CALL: begin
                    if (w_full) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_push   = 1'b1;
                        w_pc_nxt = w_zext;
                    end
                end
                PC_RET: begin
                    if (w_empty) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_top;
                    end
                end
`else
                PC_CALL:   w_pc_nxt = w_zext;
`endif
                default:   w_pc_nxt = r_pc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    assign pc_out = r_pc;

`ifdef PC_UNIT_STACK_EN
    // The return address is the already-incremented pc, so RET resumes after the CALL.
    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top_data  (w_top),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign stk_full  = w_full;
    assign stk_empty = w_empty;
    assign stk_err   = r_err;
`else
    assign stk_full  = 1'b0;
    assign stk_empty = 1'b1;
    assign stk_err   = 1'b0;
`endif

endmodule : pc_unit

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed self-checking bench for pc_unit; follows the
//               PC_UNIT_STACK_EN build option of the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        en_in;
    logic [2:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic [15:0] pc_out;
    logic        stk_full;
    logic        stk_empty;
    logic        stk_err;

    int n_chk;
    int n_err;

    pc_unit #(
        .ADDR_W      (16),
        .OFFS_W      (8),
        .STACK_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_in       (en_in),
        .pc_ctrl     (pc_ctrl),
        .offset_addr (offset_addr),
        .pc_out      (pc_out),
        .stk_full    (stk_full),
        .stk_empty   (stk_empty),
        .stk_err     (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic [2:0] ctrl, input logic [7:0] off);
        en_in       = en;
        pc_ctrl     = ctrl;
        offset_addr = off;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [15:0] pc, input logic full,
                          input logic empty, input logic err);
        chk({tag, ".pc"},    {16'h0, pc_out}, {16'h0, pc});
        chk({tag, ".full"},  {31'h0, stk_full},  {31'h0, full});
        chk({tag, ".empty"}, {31'h0, stk_empty}, {31'h0, empty});
        chk({tag, ".err"},   {31'h0, stk_err},   {31'h0, err});
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        en_in       = 1'b0;
        pc_ctrl     = 3'b000;
        offset_addr = 8'h00;
        rst         = 1'b1;
        #1 rst = 1'b0;
        #3;
        chk_st("reset", 16'h0000, 1'b0, 1'b1, 1'b0);
        #4 rst = 1'b1;

        step(1'b1, 3'b001, 8'h00);
        chk_st("inc1", 16'h0001, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b001, 8'h00);
        step(1'b1, 3'b001, 8'h00);
        chk_st("inc3", 16'h0003, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'b001, 8'h00);
        step(1'b0, 3'b001, 8'h00);
        chk_st("en_off", 16'h0003, 1'b0, 1'b1, 1'b0);

        step(1'b1, 3'b010, 8'h10);
        chk_st("jump10", 16'h0010, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b011, 8'hF8);
        chk_st("br_neg", 16'h0008, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b011, 8'h7F);
        chk_st("br_pos", 16'h0087, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b010, 8'hFF);
        chk_st("jump_zext", 16'h00FF, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b010, 8'h02);
        step(1'b1, 3'b011, 8'hFC);
        chk_st("br_wrap", 16'hFFFE, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b001, 8'h00);
        chk_st("inc_ffff", 16'hFFFF, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b001, 8'h00);
        chk_st("inc_wrap", 16'h0000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b010, 8'h44);
        step(1'b1, 3'b000, 8'h11);
        chk_st("hold", 16'h0044, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b110, 8'h11);
        chk_st("ctrl110", 16'h0044, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b111, 8'h11);
        chk_st("ctrl111", 16'h0044, 1'b0, 1'b1, 1'b0);

`ifdef PC_UNIT_STACK_EN
        step(1'b1, 3'b010, 8'h05);
        step(1'b1, 3'b100, 8'h40);
        chk_st("call1", 16'h0040, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b101, 8'h00);
        chk_st("ret1", 16'h0006, 1'b0, 1'b1, 1'b0);

        step(1'b1, 3'b010, 8'h10);
        step(1'b1, 3'b100, 8'h20);
        step(1'b1, 3'b100, 8'h30);
        step(1'b1, 3'b100, 8'h40);
        chk_st("call_d3", 16'h0040, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b100, 8'h50);
        chk_st("call_full", 16'h0050, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b100, 8'h60);
        chk_st("overflow", 16'h0050, 1'b1, 1'b0, 1'b1);
        step(1'b1, 3'b000, 8'h00);
        chk_st("err_pulse", 16'h0050, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b101, 8'h00);
        chk_st("ret_d3", 16'h0041, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b101, 8'h00);
        chk_st("ret_d2", 16'h0031, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b101, 8'h00);
        chk_st("ret_d1", 16'h0021, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b101, 8'h00);
        chk_st("ret_d0", 16'h0011, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b101, 8'h00);
        chk_st("underflow", 16'h0011, 1'b0, 1'b1, 1'b1);
        step(1'b0, 3'b101, 8'h00);
        chk_st("en_off_err", 16'h0011, 1'b0, 1'b1, 1'b0);

        step(1'b1, 3'b100, 8'h70);
        step(1'b1, 3'b100, 8'h80);
        chk_st("call2", 16'h0080, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_st("async_rst", 16'h0000, 1'b0, 1'b1, 1'b0);
        #1 rst = 1'b1;
        step(1'b1, 3'b101, 8'h00);
        chk_st("ret_after_rst", 16'h0000, 1'b0, 1'b1, 1'b1);
`else
        step(1'b1, 3'b010, 8'h10);
        step(1'b1, 3'b100, 8'h22);
        chk_st("call_as_jump", 16'h0022, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b101, 8'h55);
        chk_st("ret_as_hold", 16'h0022, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b100, 8'h33);
        chk_st("call_as_jump2", 16'h0033, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_st("async_rst", 16'h0000, 1'b0, 1'b1, 1'b0);
        #1 rst = 1'b1;
        step(1'b1, 3'b001, 8'h00);
        chk_st("inc_after_rst", 16'h0001, 1'b0, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_pc_unit

`default_nettype wire
